// File: rtl/pc88_loader_pkg.sv
// Shared types for the HPS ioctl -> PC-88 loader bridge.
// State encoding, default loader address width and FIFO entry layout.
package pc88_loader_pkg;

  localparam int LDR_ADR_W = 19;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } ldr_state_e;

  typedef struct packed {
    logic [LDR_ADR_W-1:0] adr;
    logic [7:0]           data;
  } ldr_entry_t;

endpackage

// File: rtl/ldr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinct.
module ldr_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign dout  = mem[rp[AW-1:0]];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

  // read/write pointers, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/ioctl_loader_bridge.sv
// Bridges the HPS ioctl download port onto the PC-88 LOADER_* port.
// Buffers bytes, runs one req/ack per byte and raises boot/done flags.
module ioctl_loader_bridge
  import pc88_loader_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADR_W       = LDR_ADR_W,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  output logic [ADR_W-1:0] ldr_adr,
  output logic [7:0]       ldr_wdat,
  output logic             ldr_oe,
  output logic             ldr_wr,
  input  logic             ldr_ack,
  output logic             ldr_done,
  output logic             boot_release,
  output logic [19:0]      byte_count,
  output logic             err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADR_W + 8;

  ldr_state_e state;
  ldr_state_e state_nx;

  logic          old_download;
  logic          old_ack;
  logic          dl_rise;
  logic          dl_fall;
  logic          ack_rise;
  logic          in_range;
  logic          wr_load;
  logic          push;
  logic          pop;
  logic          busy;
  logic          drained;
  logic          tmo_hit;
  logic [12:0]   tmo;
  logic [EW-1:0] fifo_din;
  logic [EW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign dl_rise  = ~old_download & ioctl_download;
  assign dl_fall  = old_download & ~ioctl_download;
  assign ack_rise = ~old_ack & ldr_ack;

  assign in_range = (ioctl_addr[24:ADR_W] == '0);
  assign wr_load  = (state == LOAD) & ioctl_wr;
  assign push     = wr_load & in_range & ~fifo_full;
  assign pop      = busy & ~ldr_wr & ~fifo_empty;
  assign drained  = fifo_empty & ~ldr_wr;
  assign tmo_hit  = ldr_wr & ~ack_rise &
                    (tmo == 13'(ACK_TIMEOUT - 1));
  assign fifo_din = {ioctl_addr[ADR_W-1:0], ioctl_dout};

  ldr_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // previous-cycle copies of download and ack for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_download <= 1'b0;
      old_ack      <= 1'b0;
    end else begin
      old_download <= ioctl_download;
      old_ack      <= ldr_ack;
    end
  end

  // state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic; DONE is terminal until reset
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (dl_rise) state_nx = LOAD;
      LOAD:    if (dl_fall) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs: loader owns SDRAM in LOAD and DRAIN
  always_comb begin
    busy   = (state == LOAD) || (state == DRAIN);
    ldr_oe = busy;
  end

  // one outstanding request: issue from FIFO head, retire on ack or timeout
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ldr_wr     <= 1'b0;
      ldr_adr    <= '0;
      ldr_wdat   <= '0;
      tmo        <= '0;
      byte_count <= '0;
    end else if (pop) begin
      ldr_wr               <= 1'b1;
      {ldr_adr, ldr_wdat}  <= fifo_dout;
      tmo                  <= '0;
    end else if (ldr_wr) begin
      if (ack_rise) begin
        ldr_wr     <= 1'b0;
        byte_count <= byte_count + 20'd1;
      end else if (tmo_hit) begin
        ldr_wr <= 1'b0;
      end else begin
        tmo <= tmo + 13'd1;
      end
    end
  end

  // back-pressure and sticky status flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wait   <= 1'b0;
      boot_release <= 1'b0;
      ldr_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      ioctl_wait <= (state == LOAD) &&
                    (fifo_count >= CW'(DEPTH - 1));
      if ((state == IDLE) && dl_rise) begin
        boot_release <= 1'b1;
      end
      if ((state == DRAIN) && drained) begin
        ldr_done <= 1'b1;
      end
      if ((wr_load & (~in_range | fifo_full)) | tmo_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Bench for ioctl_loader_bridge: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ioctl_loader_bridge;

  localparam int DEPTH = 8;
  localparam int ADR_W = 19;
  localparam int TMO   = 64;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [18:0] ldr_adr;
  logic [7:0]  ldr_wdat;
  logic        ldr_oe;
  logic        ldr_wr;
  logic        ldr_ack = 1'b0;
  logic        ldr_done;
  logic        boot_release;
  logic [19:0] byte_count;
  logic        err;

  int vecs = 0;
  int bad  = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_loader_bridge #(
    .DEPTH       (DEPTH),
    .ADR_W       (ADR_W),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_adr        (ldr_adr),
    .ldr_wdat       (ldr_wdat),
    .ldr_oe         (ldr_oe),
    .ldr_wr         (ldr_wr),
    .ldr_ack        (ldr_ack),
    .ldr_done       (ldr_done),
    .boot_release   (boot_release),
    .byte_count     (byte_count),
    .err            (err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic expired(input string name);
    vecs++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // reference model state
  int          phase = 0;
  logic [26:0] m_q[$];
  logic [19:0] m_cnt = '0;
  logic        m_err = 1'b0;
  logic        m_boot = 1'b0;
  logic        m_done = 1'b0;
  logic        m_wait = 1'b0;
  logic        m_wr_exp = 1'b0;
  logic        prev_dl = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_wr = 1'b0;
  bit          chk_en = 1'b0;
  bit          saw_wait = 1'b0;
  int          run = 0;
  int          max_run = 0;
  int          rises = 0;

  always @(negedge clk_sys) begin : model
    int          sz;
    logic        dlr;
    logic        dlf;
    logic        ar;
    logic [26:0] h;
    if (chk_en) begin
      chk("byte_count", 32'(byte_count), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      chk("boot_release", 32'(boot_release), 32'(m_boot));
      chk("ldr_done", 32'(ldr_done), 32'(m_done));
      chk("ldr_oe", 32'(ldr_oe), 32'(phase == 1 || phase == 2));
      chk("ioctl_wait", 32'(ioctl_wait), 32'(m_wait));
      chk("ldr_wr", 32'(ldr_wr), 32'(m_wr_exp));
      if (ldr_wr === 1'b1 && !prev_wr) begin
        rises++;
        if (m_q.size() > 0) h = m_q.pop_front();
        else h = '1;
        chk("ldr_adr", 32'(ldr_adr), 32'(h[26:8]));
        chk("ldr_wdat", 32'(ldr_wdat), 32'(h[7:0]));
      end
    end
    if (ioctl_wait === 1'b1) saw_wait = 1'b1;
    if (reset) begin
      phase = 0;
      m_q.delete();
      m_cnt = '0;
      m_err = 1'b0;
      m_boot = 1'b0;
      m_done = 1'b0;
      m_wait = 1'b0;
      m_wr_exp = 1'b0;
      run = 0;
      prev_dl = 1'b0;
      prev_ack = 1'b0;
      prev_wr = 1'b0;
      chk_en = 1'b1;
    end else begin
      dlr = ioctl_download && !prev_dl;
      dlf = !ioctl_download && prev_dl;
      ar  = ldr_ack && !prev_ack;
      run = ldr_wr ? run + 1 : 0;
      if (run > max_run) max_run = run;
      sz = m_q.size();
      if (ldr_wr) m_wr_exp = !(ar || run == TMO);
      else m_wr_exp = (phase == 1 || phase == 2) && sz > 0;
      if (ldr_wr && ar) m_cnt++;
      else if (ldr_wr && run == TMO) m_err = 1'b1;
      m_wait = (phase == 1) && (sz >= DEPTH - 1);
      if (phase == 1 && ioctl_wr) begin
        if (ioctl_addr >= 25'(1 << ADR_W) || sz >= DEPTH) m_err = 1'b1;
        else m_q.push_back({ioctl_addr[ADR_W-1:0], ioctl_dout});
      end
      case (phase)
        0: if (dlr) begin phase = 1; m_boot = 1'b1; end
        1: if (dlf) phase = 2;
        2: if (sz == 0 && !ldr_wr) begin phase = 3; m_done = 1'b1; end
        default: ;
      endcase
      prev_dl  = ioctl_download;
      prev_ack = ldr_ack;
      prev_wr  = ldr_wr;
    end
  end

  // core side: one ack pulse ack_delay cycles after each request rises
  int ack_delay = 3;
  bit core_en = 1'b1;
  int skip_req = -1;
  int req_idx = 0;

  initial begin : core
    int age;
    bit skip;
    age = 0;
    skip = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset || ldr_wr !== 1'b1) begin
        age = 0;
        ldr_ack = 1'b0;
      end else begin
        age++;
        if (age == 1) begin
          req_idx++;
          skip = (req_idx == skip_req);
        end
        ldr_ack = core_en && !skip && !ldr_ack && (age > ack_delay);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic dl_start();
    ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    if (n >= 500) expired("hps_wait");
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (ldr_done !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) expired("ldr_done");
    tick(2);
  endtask

  task automatic dl_end_wait();
    ioctl_download = 1'b0;
    wait_done();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : main
    int r0;
    do_reset();
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_boot", 32'(boot_release), 0);
    chk("rst_oe", 32'(ldr_oe), 0);
    chk("rst_wr", 32'(ldr_wr), 0);

    // 16-byte download, ack 3 cycles after each request
    dl_start();
    chk("s1_boot", 32'(boot_release), 1);
    chk("s1_oe", 32'(ldr_oe), 1);
    for (int i = 0; i < 16; i++) wr_byte(25'(i), 8'(i) ^ 8'hA5);
    dl_end_wait();
    chk("s1_count", 32'(byte_count), 16);
    chk("s1_done", 32'(ldr_done), 1);
    chk("s1_err", 32'(err), 0);
    chk("s1_oe_off", 32'(ldr_oe), 0);
    chk("s1_last_adr", 32'(ldr_adr), 32'h0F);
    chk("s1_last_wdat", 32'(ldr_wdat), 32'hAA);

    // core stalls 20 cycles while HPS streams
    do_reset();
    core_en = 1'b0;
    saw_wait = 1'b0;
    dl_start();
    fork
      for (int i = 0; i < 12; i++) wr_byte(25'(12'h200 + i), 8'(i * 7));
      begin
        tick(20);
        core_en = 1'b1;
      end
    join
    dl_end_wait();
    chk("s2_saw_wait", 32'(saw_wait), 1);
    chk("s2_count", 32'(byte_count), 12);
    chk("s2_err", 32'(err), 0);

    // out-of-range byte then a legal one
    do_reset();
    dl_start();
    wr_byte(25'h80000, 8'h5A);
    tick(3);
    chk("s3_err", 32'(err), 1);
    chk("s3_no_req", 32'(ldr_wr), 0);
    chk("s3_count0", 32'(byte_count), 0);
    wr_byte(25'h00010, 8'h3C);
    dl_end_wait();
    chk("s3_count1", 32'(byte_count), 1);
    chk("s3_adr", 32'(ldr_adr), 32'h10);
    chk("s3_wdat", 32'(ldr_wdat), 32'h3C);

    // second request is never acknowledged
    do_reset();
    skip_req = req_idx + 2;
    max_run = 0;
    dl_start();
    for (int i = 0; i < 3; i++) wr_byte(25'(12'h300 + i), 8'(8'hC0 + i));
    dl_end_wait();
    skip_req = -1;
    chk("s4_req_len", 32'(max_run), 64);
    chk("s4_err", 32'(err), 1);
    chk("s4_count", 32'(byte_count), 2);
    chk("s4_done", 32'(ldr_done), 1);
    chk("s4_last_adr", 32'(ldr_adr), 32'h302);

    // download ends with bytes still queued, then a late second download
    do_reset();
    ack_delay = 6;
    dl_start();
    for (int i = 0; i < 5; i++) wr_byte(25'(12'h400 + i), 8'(8'h11 * (i + 1)));
    ioctl_download = 1'b0;
    tick(1);
    chk("s5_oe_drain", 32'(ldr_oe), 1);
    chk("s5_done_early", 32'(ldr_done), 0);
    wait_done();
    chk("s5_count", 32'(byte_count), 5);
    chk("s5_oe_off", 32'(ldr_oe), 0);
    chk("s5_last_wdat", 32'(ldr_wdat), 32'h55);
    r0 = rises;
    dl_start();
    for (int i = 0; i < 3; i++) wr_byte(25'(12'h480 + i), 8'(i));
    ioctl_download = 1'b0;
    tick(5);
    chk("s5_no_req", rises - r0, 0);
    chk("s5_wait", 32'(ioctl_wait), 0);
    chk("s5_count_hold", 32'(byte_count), 5);
    ack_delay = 3;

    // reset while a request is pending and bytes are queued
    do_reset();
    core_en = 1'b0;
    dl_start();
    for (int i = 0; i < 4; i++) wr_byte(25'(12'h500 + i), 8'(8'h60 + i));
    tick(2);
    chk("s6_wr_pending", 32'(ldr_wr), 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(1);
    chk("s6_rst_wr", 32'(ldr_wr), 0);
    chk("s6_rst_adr", 32'(ldr_adr), 0);
    chk("s6_rst_wdat", 32'(ldr_wdat), 0);
    chk("s6_rst_boot", 32'(boot_release), 0);
    chk("s6_rst_oe", 32'(ldr_oe), 0);
    chk("s6_rst_wait", 32'(ioctl_wait), 0);
    reset = 1'b0;
    core_en = 1'b1;
    tick(3);
    chk("s6_idle_wr", 32'(ldr_wr), 0);
    dl_start();
    wr_byte(25'h00600, 8'h77);
    wr_byte(25'h00601, 8'h78);
    dl_end_wait();
    chk("s6_count", 32'(byte_count), 2);
    chk("s6_last_adr", 32'(ldr_adr), 32'h601);
    chk("s6_err", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/ioctl_loader_bridge.md
Name: ioctl_loader_bridge

Overview:
- Sits between the HPS ioctl download port and the PC-88 core LOADER_* interface.
- Buffers incoming ROM bytes in a small FIFO and applies back-pressure to the HPS through ioctl_wait.
- Issues one req/ack transfer per byte toward the core's SDRAM loader.
- Produces the sticky boot-release and load-done flags that gate core reset.

Parameters:
DEPTH, 8, FIFO entries; power of two, 4..64
ADR_W, 19, loader address width; bytes at ioctl_addr >= 2**ADR_W are dropped
ACK_TIMEOUT, 4096, clk_sys cycles to wait for ldr_ack before abandoning a byte

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  HPS download active
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to HPS
ldr_adr  out  ADR_W  loader address
ldr_wdat  out  8  loader data
ldr_oe  out  1  loader owns SDRAM (LOAD or DRAIN)
ldr_wr  out  1  write request, held until ack
ldr_ack  in  1  core acknowledge (level; rising edge counts)
ldr_done  out  1  sticky: download complete and drained
boot_release  out  1  sticky: first download started (drives reset_n)
byte_count  out  20  bytes acknowledged by core
err  out  1  sticky: byte dropped (range, overflow or timeout)

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Reset mid-operation discards FIFO and pending byte.
- Sticky flags (ldr_done, boot_release, err) are cleared only by reset.
- Edge detection: old_download and old_ack are registered each cycle.
- Download rising edge = ~old_download & ioctl_download; falling edge = old_download & ~ioctl_download.
- Ack rising edge = ~old_ack & ldr_ack.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on download rising edge -> LOAD; set boot_release.
  - LOAD: accept bytes; on download falling edge -> DRAIN.
  - DRAIN: when FIFO empty and ldr_wr=0 -> DONE; set ldr_done the same cycle.
  - DONE: terminal. Further downloads are ignored: no FIFO writes, ioctl_wait=0, ldr_oe=0.
- FIFO push, LOAD only: ioctl_wr & addr < 2**ADR_W & not full pushes {addr[ADR_W-1:0], data}.
  - Out-of-range address: byte dropped, err set.
  - Write while full: byte dropped, err set.
  - A push on the same cycle as the falling edge is still accepted.
- ioctl_wait is registered, = (count >= DEPTH-1) while in LOAD. This one-cycle slack means a compliant HPS never overflows.
- Pop: when ldr_wr=0 and FIFO not empty (LOAD or DRAIN), load ldr_adr/ldr_wdat and set ldr_wr=1 on the next edge.
  - Latency, empty FIFO: ioctl_wr at cycle N -> ldr_wr high at N+2.
  - Push and pop on the same cycle are allowed; count stays unchanged.
- Transfer completion:
  - ldr_wr stays high until an ack rising edge is seen while ldr_wr=1. Then ldr_wr->0 and byte_count increments (wraps at 2**20).
  - Earliest next ldr_wr is 1 cycle after it drops.
  - An ack high at the moment ldr_wr rises does not count. A fresh rising edge is required.
- Timeout: a 13-bit cycle counter runs while ldr_wr=1 and resets on each new request. Reaching ACK_TIMEOUT drops ldr_wr, sets err, and does not increment byte_count.
- Arithmetic: FIFO pointers are log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal.

Decomposition:
- Shared package pc88_loader_pkg holds:
  - state enum (IDLE, LOAD, DRAIN, DONE)
  - LDR_ADR_W=19
  - typedef ldr_entry_t {adr, data}
- One sub-module: ldr_sync_fifo, a parameterised single-clock FIFO with count, full and empty outputs, synchronous reset.
- FSM, edge detect, handshake and timeout stay in the top.

Test Plan:
- Reset then download of 16 bytes at addr 0..15, data=addr^8'hA5, core acks 3 cycles after each ldr_wr. Required: 16 ldr_wr pulses in order with matching adr/wdat; byte_count=16; ldr_done rises after the last ack; err=0.
- Core holds ack low for 20 cycles while HPS writes every cycle with DEPTH=8. Required: ioctl_wait=1 once count reaches 7; no bytes dropped; err=0.
- Write at ioctl_addr=25'h80000. Required: no push, err=1, byte_count unchanged; a following byte at 0x00010 transfers normally.
- Core never acks one byte, ACK_TIMEOUT=64. Required: ldr_wr drops exactly 64 cycles after rising, err=1, next byte issued; ldr_done still reached after drain.
- Download ends with 5 bytes queued. Required: state DRAIN, ldr_oe stays 1 until the 5th ack; then ldr_done=1 and ldr_oe=0. A second download causes no ldr_wr and keeps ioctl_wait=0.
- Assert reset mid-transfer with ldr_wr=1 and 3 entries queued. Required: all outputs 0 the next cycle; a new download restarts from IDLE with an empty FIFO.
